// File: rtl/duck_sprite_scheduler.sv
// duck_sprite_scheduler: picks the winning duck per pixel, addresses the shared sprite ROM and aligns the texel with the duck ID.
// Optional horizontal mirroring is enabled by defining DUCK_SCHED_MIRROR_EN, which adds the duck_flip input.
module duck_sprite_scheduler #(
    parameter int NUM_DUCKS    = 4,
    parameter int SPRITE_DIM   = 64,
    parameter int FRAMES       = 4,
    parameter int FRAME_PERIOD = 8,
    localparam int DW = $clog2(SPRITE_DIM),
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int AW = 2 * DW + $clog2(FRAMES),
    localparam int IW = (NUM_DUCKS > 1) ? $clog2(NUM_DUCKS) : 1
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    blank,
    input  logic                    frame_start,
    input  logic [10*NUM_DUCKS-1:0] duck_x,
    input  logic [10*NUM_DUCKS-1:0] duck_y,
    input  logic [NUM_DUCKS-1:0]    duck_en,
`ifdef DUCK_SCHED_MIRROR_EN
    input  logic [NUM_DUCKS-1:0]    duck_flip,
`endif
    input  logic                    anim_hold,
    output logic [AW-1:0]           rom_address,
    input  logic [3:0]              rom_q,
    output logic                    pix_valid,
    output logic [3:0]              pix_index,
    output logic [IW-1:0]           pix_duck,
    output logic [FW-1:0]           anim_frame
);
    localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic [10*NUM_DUCKS-1:0] r_sh_x, r_sh_y;
    logic [NUM_DUCKS-1:0]    r_sh_en;
`ifdef DUCK_SCHED_MIRROR_EN
    logic [NUM_DUCKS-1:0]    r_sh_flip;
`endif
    logic [PW-1:0]           r_period;
    logic [FW-1:0]           r_anim;
    logic                    r_hit;
    logic [IW-1:0]           r_id;
    logic                    w_any;
    logic [IW-1:0]           w_id;
    logic [DW-1:0]           w_dx, w_dy;
    logic [AW-1:0]           w_addr;

    assign anim_frame = r_anim;

    // 11-bit compare keeps origin+SPRITE_DIM from wrapping past 1023
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] o);
        return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} < {1'b0, o} + 11'(SPRITE_DIM));
    endfunction

    // Descending scan so the lowest hitting slot is the last (winning) assignment
    always_comb begin
        w_any = 1'b0;
        w_id  = '0;
        w_dx  = '0;
        w_dy  = '0;
        for (int i = NUM_DUCKS - 1; i >= 0; i--) begin
            if (r_sh_en[i] && blank && in_span(DrawX, r_sh_x[10*i +: 10]) && in_span(DrawY, r_sh_y[10*i +: 10])) begin
                w_any = 1'b1;
                w_id  = IW'(i);
                w_dy  = DW'(DrawY - r_sh_y[10*i +: 10]);
`ifdef DUCK_SCHED_MIRROR_EN
                w_dx  = r_sh_flip[i] ? ~DW'(DrawX - r_sh_x[10*i +: 10]) : DW'(DrawX - r_sh_x[10*i +: 10]);
`else
                w_dx  = DW'(DrawX - r_sh_x[10*i +: 10]);
`endif
            end
        end
        w_addr = w_any ? AW'({r_anim, w_dy, w_dx}) : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_x      <= '0;
            r_sh_y      <= '0;
            r_sh_en     <= '0;
`ifdef DUCK_SCHED_MIRROR_EN
            r_sh_flip   <= '0;
`endif
            r_period    <= '0;
            r_anim      <= '0;
            r_hit       <= 1'b0;
            r_id        <= '0;
            rom_address <= '0;
            pix_valid   <= 1'b0;
            pix_index   <= '0;
            pix_duck    <= '0;
        end else begin
            if (frame_start) begin
                r_sh_x  <= duck_x;
                r_sh_y  <= duck_y;
                r_sh_en <= duck_en;
`ifdef DUCK_SCHED_MIRROR_EN
                r_sh_flip <= duck_flip;
`endif
            end
            if (frame_start && !anim_hold) begin
                if (r_period == PW'(FRAME_PERIOD - 1)) begin
                    r_period <= '0;
                    r_anim   <= (FRAMES > 1) ? r_anim + FW'(1) : '0;
                end else begin
                    r_period <= r_period + PW'(1);
                end
            end
            rom_address <= w_addr;
            r_hit       <= w_any;
            r_id        <= w_id;
            pix_valid   <= r_hit;
            pix_index   <= r_hit ? rom_q : 4'd0;
            pix_duck    <= r_id;
        end
    end
endmodule

// File: tb/tb_duck_sprite_scheduler.sv
// tb_duck_sprite_scheduler: directed pixels feed an expectation queue; a negedge monitor compares stage-1 address and stage-2 pixel outputs.
module tb_duck_sprite_scheduler;
    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        blank = 1'b0, frame_start = 1'b0, anim_hold = 1'b0;
    logic [39:0] duck_x = '0, duck_y = '0;
    logic [3:0]  duck_en = '0;
`ifdef DUCK_SCHED_MIRROR_EN
    logic [3:0]  duck_flip = '0;
`endif
    logic [13:0] rom_address;
    logic [3:0]  rom_q = '0;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic [1:0]  pix_duck;
    logic [1:0]  anim_frame;

    duck_sprite_scheduler dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .duck_x(duck_x), .duck_y(duck_y), .duck_en(duck_en),
`ifdef DUCK_SCHED_MIRROR_EN
        .duck_flip(duck_flip),
`endif
        .anim_hold(anim_hold), .rom_address(rom_address), .rom_q(rom_q), .pix_valid(pix_valid),
        .pix_index(pix_index), .pix_duck(pix_duck), .anim_frame(anim_frame)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct { int due; string nm; int addr; } a_t;
    typedef struct { int due; string nm; int v; int idx; int d; } p_t;
    a_t aq[$];
    p_t pq[$];
    a_t ca;
    p_t cp;
    int cyc = 0, n_cmp = 0, n_bad = 0;

    // ROM image: low nibble of the address xor the frame bits, so frame 1 origin reads 1
    function automatic logic [3:0] texel(input logic [13:0] a);
        return a[3:0] ^ {2'b00, a[13:12]};
    endfunction

    always @(negedge vga_clk) rom_q <= texel(rom_address);
    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge vga_clk) begin
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ca = aq.pop_front();
            chk({ca.nm, " rom_address"}, int'(rom_address), ca.addr);
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            cp = pq.pop_front();
            chk({cp.nm, " pix_valid"}, int'(pix_valid), cp.v);
            if (cp.v != 0) begin
                chk({cp.nm, " pix_index"}, int'(pix_index), cp.idx);
                chk({cp.nm, " pix_duck"}, int'(pix_duck), cp.d);
            end
        end
    end

    task automatic px(input string nm, input int x, input int y, input int b, input int ea, input int ev, input int ei, input int ed);
        @(posedge vga_clk); #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b[0];
        aq.push_back('{cyc + 1, nm, ea});
        pq.push_back('{cyc + 2, nm, ev, ei, ed});
    endtask

    task automatic pulse(input logic hold);
        @(posedge vga_clk); #1;
        blank = 1'b0;
        frame_start = 1'b1;
        anim_hold = hold;
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " rom_address"}, int'(rom_address), 0);
        chk({nm, " pix_valid"}, int'(pix_valid), 0);
        chk({nm, " pix_index"}, int'(pix_index), 0);
        chk({nm, " pix_duck"}, int'(pix_duck), 0);
        chk({nm, " anim_frame"}, int'(anim_frame), 0);
    endtask

    initial begin
        repeat (2) @(posedge vga_clk);
        #1 chk_zero("reset");
        reset_n = 1'b1;
        duck_x[9:0] = 10'd100;
        duck_y[9:0] = 10'd50;
        duck_en = 4'b0001;
        px("pre_fs", 100, 50, 1, 0, 0, 0, 0);
        pulse(1'b1);
        chk("hold_setup anim_frame", int'(anim_frame), 0);
        px("origin", 100, 50, 1, 0, 1, 0, 0);
        px("dx1", 101, 50, 1, 1, 1, 1, 0);
        px("top_right", 163, 50, 1, 63, 1, 15, 0);
        px("far_corner", 163, 113, 1, 4095, 1, 15, 0);
        px("right_out", 164, 113, 1, 0, 0, 0, 0);
        px("left_out", 99, 50, 1, 0, 0, 0, 0);
        px("blanked", 100, 50, 0, 0, 0, 0, 0);
        duck_x[9:0] = 10'd300;
        px("tear_old", 100, 50, 1, 0, 1, 0, 0);
        px("tear_new_early", 300, 50, 1, 0, 0, 0, 0);
        pulse(1'b1);
        px("tear_new", 300, 50, 1, 0, 1, 0, 0);
        px("tear_old_gone", 100, 50, 1, 0, 0, 0, 0);
`ifdef DUCK_SCHED_MIRROR_EN
        duck_x[9:0] = 10'd100;
        duck_flip = 4'b0001;
        pulse(1'b1);
        px("mirror_origin", 100, 50, 1, 63, 1, 15, 0);
        px("mirror_right", 163, 50, 1, 0, 1, 0, 0);
        duck_flip = 4'b0000;
`endif
        duck_x[9:0] = 10'd620;
        pulse(1'b1);
        px("edge_first", 620, 50, 1, 0, 1, 0, 0);
        px("edge_last", 639, 50, 1, 19, 1, 3, 0);
        px("edge_nowrap0", 0, 50, 1, 0, 0, 0, 0);
        px("edge_nowrap43", 43, 50, 1, 0, 0, 0, 0);
        duck_en = 4'b0110;
        duck_x[19:10] = 10'd200;
        duck_y[19:10] = 10'd200;
        duck_x[29:20] = 10'd180;
        duck_y[29:20] = 10'd180;
        pulse(1'b1);
        px("overlap_transp", 200, 200, 1, 0, 1, 0, 1);
        px("slot2_only", 190, 190, 1, 650, 1, 10, 2);
        px("overlap_opaque", 250, 250, 1, 3250, 1, 2, 1);
        duck_en = 4'b0001;
        duck_x[9:0] = 10'd100;
        pulse(1'b1);
        repeat (8) pulse(1'b1);
        chk("held8 anim_frame", int'(anim_frame), 0);
        repeat (7) pulse(1'b0);
        chk("seven anim_frame", int'(anim_frame), 0);
        pulse(1'b0);
        chk("eight anim_frame", int'(anim_frame), 1);
        px("frame1_origin", 100, 50, 1, 4096, 1, 1, 0);
        repeat (24) pulse(1'b0);
        chk("wrap32 anim_frame", int'(anim_frame), 0);
        repeat (8) pulse(1'b0);
        chk("pre_reset anim_frame", int'(anim_frame), 1);
        px("pre_reset", 100, 50, 1, 4096, 1, 1, 0);
        px("pre_reset", 100, 50, 1, 4096, 1, 1, 0);
        @(posedge vga_clk); #3;
        reset_n = 1'b0;
        #1 chk_zero("mid_reset");
        aq.delete();
        pq.delete();
        repeat (2) @(posedge vga_clk);
        #1 reset_n = 1'b1;
        repeat (3) px("post_reset", 100, 50, 1, 0, 0, 0, 0);
        pulse(1'b1);
        px("post_reset_fs", 100, 50, 1, 0, 1, 0, 0);
        repeat (4) @(posedge vga_clk);
        #1 chk("drain", aq.size() + pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/duck_sprite_scheduler.md
# duck_sprite_scheduler

Per-pixel scheduler that shares one 64x64, 4-bit-index duck sprite ROM between up to NUM_DUCKS on-screen ducks. It sits between the VGA timing counters and the sprite ROM/palette. Each pixel, it picks the winning duck, forms the ROM address from the duck-relative offset and the current animation frame, and returns the palette index with the duck ID, aligned to the pipeline. Duck positions are latched once per video frame, so mid-frame game-logic updates never tear.

## Interface
- NUM_DUCKS, 4: number of duck slots (1..8).
- SPRITE_DIM, 64: sprite width and height in pixels (power of two).
- FRAMES, 4: animation frames stored back-to-back in the ROM (power of two).
- FRAME_PERIOD, 8: video frames per animation step (>=1).
- vga_clk  in  1: pixel clock. All logic is posedge.
- reset_n  in  1: asynchronous, active-low reset.
- DrawX, DrawY  in  10 each: current pixel coordinates.
- blank  in  1: 1 = active video (same sense as the rest of the video path).
- frame_start  in  1: one-cycle pulse at the start of vertical blanking.
- duck_x, duck_y  in  10*NUM_DUCKS each: top-left corner of each duck. Slot i is bits [10i+9:10i].
- duck_en  in  NUM_DUCKS: slot enable.
- anim_hold  in  1: freezes the animation counter.
- rom_address  out  log2(SPRITE_DIM²·FRAMES) (14 at defaults): sprite ROM address.
- rom_q  in  4: ROM data. Must be valid at the posedge one cycle after rom_address changes (negedge-clocked ROM).
- pix_valid  out  1: the current pixel is covered by a duck.
- pix_index  out  4: palette index (0 = transparent).
- pix_duck  out  log2(NUM_DUCKS) (min 1): winning slot.
- anim_frame  out  log2(FRAMES): current animation frame.

## Operation
- Shadow registers: on a frame_start pulse, the block copies duck_x, duck_y and duck_en (and duck_flip) into shadow registers. All hit tests use only the shadow copies.
- Hit test for slot i: sh_en[i] && blank && DrawX ∈ [sh_x, sh_x+SPRITE_DIM) && DrawY ∈ [sh_y, sh_y+SPRITE_DIM).
  - Compare in 11 bits so the sum sh_x+SPRITE_DIM never wraps. A duck at x=620 is hit for DrawX 620..639 only.
- Arbitration: the lowest-index hitting slot wins. This is fixed priority and has no fall-through. If the winner's texel is transparent, lower-priority ducks do not show through; the output is index 0 with pix_valid=1.
- Address = anim_frame·SPRITE_DIM² + dy·SPRITE_DIM + dx, where dx = DrawX−sh_x and dy = DrawY−sh_y.
  - This is pure bit concatenation: {anim_frame, dy[5:0], dx[5:0]} at defaults.
  - With no hit, the address is driven to 0.
- Animation:
  - A period counter counts frame_start pulses while anim_hold=0.
  - When the counter reaches FRAME_PERIOD−1, it resets to 0 and anim_frame increments modulo FRAMES, wrapping from FRAMES−1 to 0.
  - anim_hold=1 freezes both the counter and anim_frame.
  - anim_frame changes only on frame_start, never inside active video.

## Timing
- Pipeline, for pixel coordinates presented in cycle n:
  - Stage 1 (end of n): register rom_address, hit_any and winner ID.
  - Stage 2 (end of n+1): register rom_q into pix_index, and the delayed hit/ID into pix_valid/pix_duck.
  - Outputs for pixel n are valid in cycle n+2, a fixed latency of 2. Consumers delay DrawX/DrawY/blank by 2 to match.
- The shadow update takes effect for the pixel presented in the cycle after the frame_start pulse.
- frame_start during active video is still honoured and may tear; keeping it in blanking is the caller's contract.
- Reset (async assert, any cycle, including mid-line or mid-frame) immediately forces:
  - all outputs, the period counter and anim_frame to 0;
  - shadow enables to 0, so no duck is visible until the first frame_start after release.
- After reset release, the pipeline produces pix_valid=0 until real hits reach stage 2.
- frame_start and anim_hold in the same cycle: shadow copy happens; animation does not advance.

## Configuration
- DUCK_SCHED_MIRROR_EN:
  - Defined: adds input duck_flip [NUM_DUCKS], shadowed with the other duck inputs. When the winner's flip bit is 1, dx is replaced by SPRITE_DIM−1−dx, giving a horizontally mirrored duck. Latency is unchanged.
  - Undefined: no duck_flip port, and dx is always used unmodified.

## Test plan
- Single duck: slot 0 at (100,50), enabled, frame_start, anim_frame=0. At DrawX=100, DrawY=50 → rom_address=0. At DrawX=163, DrawY=113 → rom_address=4095. pix_valid=1 two cycles later. At DrawX=164 → pix_valid=0.
- Overlap: slots 1 and 2 both cover (200,200), slot 1 with a transparent texel → pix_duck=1, pix_index=0, pix_valid=1.
- Edge clip: duck at x=620 → hits at DrawX 620..639 only, with no wrap-around hit at DrawX 0..43. blank=0 → pix_valid=0 everywhere.
- Animation:
  - 8 frame_start pulses → anim_frame 0→1, and the address at the duck origin becomes 4096.
  - 32 pulses → anim_frame wraps to 0.
  - anim_hold high across 8 pulses → anim_frame unchanged.
- Tear-free update: change duck_x mid-frame → the output is unchanged until after the next frame_start.
- Reset: assert reset_n=0 mid-line → all outputs are 0 that cycle. After release and before frame_start, pix_valid stays 0.
- Mirror (DUCK_SCHED_MIRROR_EN defined): duck_flip[0]=1, duck at (100,50), pixel (100,50) → rom_address=63.
